// File: rtl/sv32_tlb_nway_if.sv
`default_nettype none
// ============================================================================
//  Module      : sv32_tlb_nway_if
//  Description : Bus bundle between the N-way Sv32 TLB and its clients.
//                master = MMU translate stage + page-table walker side,
//                slave  = the TLB itself.
//                Groups: lookup request/response, refill write, flush
//                request/status, hit/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sv32_tlb_nway_if #(
    parameter int CNT_W = 32
);
    // lookup request / response
    logic             lk_valid;
    logic             lk_ready;
    logic [19:0]      lk_vpn;
    logic [8:0]       lk_asid;
    logic             rsp_valid;
    logic             rsp_hit;
    logic [21:0]      rsp_ppn;
    logic [7:0]       rsp_perm;
    logic             rsp_mega;
    // refill from the page-table walker
    logic             fill_valid;
    logic [19:0]      fill_vpn;
    logic [8:0]       fill_asid;
    logic [21:0]      fill_ppn;
    logic [7:0]       fill_perm;
    logic             fill_mega;
    // flush
    logic             flush_valid;
    logic [1:0]       flush_mode;
    logic [19:0]      flush_vpn;
    logic [8:0]       flush_asid;
    logic             flush_busy;
    // statistics
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        output lk_valid, lk_vpn, lk_asid,
        output fill_valid, fill_vpn, fill_asid, fill_ppn, fill_perm, fill_mega,
        output flush_valid, flush_mode, flush_vpn, flush_asid,
        input  lk_ready, rsp_valid, rsp_hit, rsp_ppn, rsp_perm, rsp_mega,
        input  flush_busy, hit_count, miss_count
    );

    modport slave (
        input  lk_valid, lk_vpn, lk_asid,
        input  fill_valid, fill_vpn, fill_asid, fill_ppn, fill_perm, fill_mega,
        input  flush_valid, flush_mode, flush_vpn, flush_asid,
        output lk_ready, rsp_valid, rsp_hit, rsp_ppn, rsp_perm, rsp_mega,
        output flush_busy, hit_count, miss_count
    );
endinterface : sv32_tlb_nway_if
`default_nettype wire

// File: rtl/sv32_tlb_nway.sv
`default_nettype none
// ============================================================================
//  Module      : sv32_tlb_nway
//  Description : Parametrised N-way set-associative Sv32 TLB with 4 MiB
//                megapage entries, per-set round-robin replacement,
//                flush-all / selective (ASID, VPN, VPN+ASID) sweep flush and
//                saturating hit/miss counters.
//  Ports       : clk, reset (async, active-high)
//                bus (sv32_tlb_nway_if.slave):
//                  lk_*    lookup request, 1-cycle latency rsp_* response
//                  fill_*  walker refill, honoured only in IDLE
//                  flush_* flush request, flush_busy while sweeping
//                  hit_count / miss_count saturating statistics
//  Options     : define SV32_TLB_ASID_EN to store and compare ASID tags.
//                Without it ASIDs are ignored, mode 01 acts as 00 and
//                mode 11 acts as 10.
//  Revision    : 1.0 - initial release
// ============================================================================
module sv32_tlb_nway #(
    parameter int SETS  = 16,
    parameter int WAYS  = 2,
    parameter int CNT_W = 32
) (
    input wire             clk,
    input wire             reset,
    sv32_tlb_nway_if.slave bus
);
    localparam int               IDX_W   = $clog2(SETS);
    localparam int               WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
`ifdef SV32_TLB_ASID_EN
    localparam int               PERM_G  = 5;
`endif

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q;
    logic             ready_q;
    logic             busy_q;
    logic [IDX_W-1:0] sweep_idx_q;
    logic [1:0]       fl_mode_q;
    logic [19:0]      fl_vpn_q;
`ifdef SV32_TLB_ASID_EN
    logic [8:0]       fl_asid_q;
`endif

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAY_W-1:0] rr_q    [SETS];
    logic [19:0]      tag_q   [SETS][WAYS];
    logic [21:0]      ppn_q   [SETS][WAYS];
    logic [7:0]       perm_q  [SETS][WAYS];
    logic             mega_q  [SETS][WAYS];
`ifdef SV32_TLB_ASID_EN
    logic [8:0]       asid_q  [SETS][WAYS];
`else
    wire              w_unused_asid = ^{bus.lk_asid, bus.fill_asid, bus.flush_asid};
`endif

    logic             rsp_valid_q;
    logic             rsp_hit_q;
    logic [21:0]      rsp_ppn_q;
    logic [7:0]       rsp_perm_q;
    logic             rsp_mega_q;
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // Megapages only carry VPN1 as a meaningful tag.
    function automatic logic tag_hit(input logic [19:0] tag, input logic mega,
                                     input logic [19:0] vpn);
        return mega ? (tag[19:10] == vpn[19:10]) : (tag == vpn);
    endfunction

    // Lowest set bit wins, giving the lowest-way priority on multi-match.
    function automatic logic [WAY_W-1:0] first_one(input logic [WAYS-1:0] v);
        logic [WAY_W-1:0] r;
        r = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (v[w]) r = WAY_W'(w);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Way matching for lookup, fill and sweep
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_lk_idx;
    logic [IDX_W-1:0] w_fill_idx;
    logic [WAYS-1:0]  w_lk_match;
    logic [WAYS-1:0]  w_fill_match;
    logic [WAYS-1:0]  w_kill;
    logic             w_fl_vpn_m;
    logic             w_fl_asid_m;

    assign w_lk_idx   = bus.lk_vpn[10 +: IDX_W];
    assign w_fill_idx = bus.fill_vpn[10 +: IDX_W];

    always_comb begin
        w_lk_match   = '0;
        w_fill_match = '0;
        w_kill       = '0;
        w_fl_vpn_m   = 1'b0;
        w_fl_asid_m  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            w_lk_match[w]   = valid_q[w_lk_idx][w] &&
                              tag_hit(tag_q[w_lk_idx][w], mega_q[w_lk_idx][w], bus.lk_vpn);
            w_fill_match[w] = valid_q[w_fill_idx][w] &&
                              tag_hit(tag_q[w_fill_idx][w], mega_q[w_fill_idx][w], bus.fill_vpn);
            w_fl_vpn_m      = tag_hit(tag_q[sweep_idx_q][w], mega_q[sweep_idx_q][w], fl_vpn_q);
            w_fl_asid_m     = 1'b1;
`ifdef SV32_TLB_ASID_EN
            w_lk_match[w]   = w_lk_match[w] &&
                              (perm_q[w_lk_idx][w][PERM_G] || (asid_q[w_lk_idx][w] == bus.lk_asid));
            w_fill_match[w] = w_fill_match[w] &&
                              (perm_q[w_fill_idx][w][PERM_G] || (asid_q[w_fill_idx][w] == bus.fill_asid));
            // ASID-scoped flushes never touch global entries.
            w_fl_asid_m     = !perm_q[sweep_idx_q][w][PERM_G] &&
                              (asid_q[sweep_idx_q][w] == fl_asid_q);
`endif
            case (fl_mode_q)
                2'b01:   w_kill[w] = w_fl_asid_m;
                2'b10:   w_kill[w] = w_fl_vpn_m;
                default: w_kill[w] = w_fl_vpn_m && w_fl_asid_m;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic             w_idle;
    logic             w_lk_acc;
    logic             w_lk_hit;
    logic [WAY_W-1:0] w_lk_way;
    logic             w_mode_all;
    logic             w_flush_all;
    logic             w_flush_sel;
    logic             w_fill_do;
    logic [WAYS-1:0]  w_fill_inv;
    logic             w_fill_use_rr;
    logic [WAY_W-1:0] w_fill_way;
    logic [21:0]      w_lk_ppn;
    logic [21:0]      w_rsp_ppn;

    assign w_idle   = (state_q == IDLE);
    assign w_lk_acc = bus.lk_valid && ready_q;
    assign w_lk_hit = |w_lk_match;
    assign w_lk_way = first_one(w_lk_match);

`ifdef SV32_TLB_ASID_EN
    assign w_mode_all = (bus.flush_mode == 2'b00);
`else
    assign w_mode_all = (bus.flush_mode == 2'b00) || (bus.flush_mode == 2'b01);
`endif
    assign w_flush_all = bus.flush_valid && w_idle && w_mode_all;
    assign w_flush_sel = bus.flush_valid && w_idle && !w_mode_all;
    // Any flush in the same cycle wins over the refill.
    assign w_fill_do   = bus.fill_valid && w_idle && !bus.flush_valid;

    // Replacement priority: overwrite a matching way, else lowest free way,
    // else the set's round-robin victim.
    assign w_fill_inv    = ~valid_q[w_fill_idx];
    assign w_fill_use_rr = !(|w_fill_match) && !(|w_fill_inv);
    assign w_fill_way    = (|w_fill_match) ? first_one(w_fill_match) :
                           (|w_fill_inv)   ? first_one(w_fill_inv)   :
                                             rr_q[w_fill_idx];

    assign w_lk_ppn  = ppn_q[w_lk_idx][w_lk_way];
    assign w_rsp_ppn = !w_lk_hit                  ? 22'd0 :
                       mega_q[w_lk_idx][w_lk_way] ? {w_lk_ppn[21:10], bus.lk_vpn[9:0]} :
                                                    w_lk_ppn;

    // ------------------------------------------------------------------
    // Control, valid bits, replacement pointers, response, counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            sweep_idx_q <= '0;
            fl_mode_q   <= 2'b00;
            fl_vpn_q    <= '0;
`ifdef SV32_TLB_ASID_EN
            fl_asid_q   <= '0;
`endif
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_ppn_q   <= '0;
            rsp_perm_q  <= '0;
            rsp_mega_q  <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            // Response and statistics reflect the contents before this edge.
            rsp_valid_q <= w_lk_acc;
            if (w_lk_acc) begin
                rsp_hit_q  <= w_lk_hit;
                rsp_ppn_q  <= w_rsp_ppn;
                rsp_perm_q <= w_lk_hit ? perm_q[w_lk_idx][w_lk_way] : 8'd0;
                rsp_mega_q <= w_lk_hit && mega_q[w_lk_idx][w_lk_way];
                if (w_lk_hit) begin
                    if (hit_cnt_q != CNT_MAX) hit_cnt_q <= hit_cnt_q + 1'b1;
                end else begin
                    if (miss_cnt_q != CNT_MAX) miss_cnt_q <= miss_cnt_q + 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (w_flush_all) begin
                        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
                    end else if (w_flush_sel) begin
                        state_q     <= SWEEP;
                        busy_q      <= 1'b1;
                        ready_q     <= 1'b0;
                        sweep_idx_q <= '0;
                        fl_mode_q   <= bus.flush_mode;
                        fl_vpn_q    <= bus.flush_vpn;
`ifdef SV32_TLB_ASID_EN
                        fl_asid_q   <= bus.flush_asid;
`endif
                    end else if (w_fill_do) begin
                        valid_q[w_fill_idx][w_fill_way] <= 1'b1;
                        if (w_fill_use_rr) begin
                            rr_q[w_fill_idx] <= (rr_q[w_fill_idx] == WAY_W'(WAYS - 1)) ?
                                                '0 : rr_q[w_fill_idx] + 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    valid_q[sweep_idx_q] <= valid_q[sweep_idx_q] & ~w_kill;
                    sweep_idx_q          <= sweep_idx_q + 1'b1;
                    if (sweep_idx_q == IDX_W'(SETS - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Entry payload needs no reset: it is qualified by valid_q.
    always_ff @(posedge clk) begin
        if (w_fill_do) begin
            tag_q[w_fill_idx][w_fill_way]  <= bus.fill_vpn;
            ppn_q[w_fill_idx][w_fill_way]  <= bus.fill_ppn;
            perm_q[w_fill_idx][w_fill_way] <= bus.fill_perm;
            mega_q[w_fill_idx][w_fill_way] <= bus.fill_mega;
`ifdef SV32_TLB_ASID_EN
            asid_q[w_fill_idx][w_fill_way] <= bus.fill_asid;
`endif
        end
    end

    assign bus.lk_ready   = ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.rsp_ppn    = rsp_ppn_q;
    assign bus.rsp_perm   = rsp_perm_q;
    assign bus.rsp_mega   = rsp_mega_q;
    assign bus.flush_busy = busy_q;
    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;

endmodule : sv32_tlb_nway
`default_nettype wire

// File: tb/tb_sv32_tlb_nway.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sv32_tlb_nway
//  Description : Self-checking bench for sv32_tlb_nway. Directed scenarios
//                followed by randomized lookup/fill/flush traffic, compared
//                against an array-based reference model of the TLB rules.
//                Honours SV32_TLB_ASID_EN in the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sv32_tlb_nway;
    localparam int SETS  = 16;
    localparam int WAYS  = 2;
    localparam int CNT_W = 6;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef SV32_TLB_ASID_EN
    localparam bit ASID_EN = 1'b1;
`else
    localparam bit ASID_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sv32_tlb_nway_if #(.CNT_W(CNT_W)) bus ();

    sv32_tlb_nway #(
        .SETS (SETS),
        .WAYS (WAYS),
        .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit          m_v    [SETS][WAYS];
    logic [19:0] m_vpn  [SETS][WAYS];
    logic [21:0] m_ppn  [SETS][WAYS];
    logic [7:0]  m_perm [SETS][WAYS];
    bit          m_mega [SETS][WAYS];
    logic [8:0]  m_asid [SETS][WAYS];
    int          m_rr   [SETS];
    int          m_hits, m_misses;
    logic [21:0] last_ppn;

    function automatic int set_of(input logic [19:0] vpn);
        return (int'(vpn) / 1024) % SETS;
    endfunction

    function automatic bit same_page(input logic [19:0] etag, input bit emega, input logic [19:0] vpn);
        if (emega) return (int'(etag) / 1024) == (int'(vpn) / 1024);
        return etag == vpn;
    endfunction

    function automatic bit m_match(input int s, input int w, input logic [19:0] vpn, input logic [8:0] asid);
        if (!m_v[s][w]) return 1'b0;
        return same_page(m_vpn[s][w], m_mega[s][w], vpn) &&
               (!ASID_EN || m_perm[s][w][5] || m_asid[s][w] == asid);
    endfunction

    task automatic m_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_v[s][w] = 1'b0;
        end
        m_hits = 0; m_misses = 0; last_ppn = '0;
    endtask

    task automatic m_lookup(input logic [19:0] vpn, input logic [8:0] asid, output bit hit,
                            output logic [21:0] ppn, output logic [7:0] perm, output bit mega);
        int s;
        s = set_of(vpn);
        hit = 1'b0; ppn = '0; perm = '0; mega = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && m_match(s, w, vpn, asid)) begin
                hit  = 1'b1;
                perm = m_perm[s][w];
                mega = m_mega[s][w];
                ppn  = mega ? 22'((int'(m_ppn[s][w]) / 1024) * 1024 + int'(vpn) % 1024) : m_ppn[s][w];
            end
        end
        if (hit) begin if (m_hits < MAXC) m_hits++; end
        else     begin if (m_misses < MAXC) m_misses++; end
    endtask

    task automatic m_fill(input logic [19:0] vpn, input logic [8:0] asid, input logic [21:0] ppn,
                          input logic [7:0] perm, input bit mega);
        int s, way;
        s = set_of(vpn); way = -1;
        for (int w = 0; w < WAYS; w++) if (way < 0 && m_match(s, w, vpn, asid)) way = w;
        for (int w = 0; w < WAYS; w++) if (way < 0 && !m_v[s][w]) way = w;
        if (way < 0) begin
            way = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % WAYS;
        end
        m_v[s][way] = 1'b1; m_vpn[s][way] = vpn; m_ppn[s][way] = ppn;
        m_perm[s][way] = perm; m_mega[s][way] = mega; m_asid[s][way] = asid;
    endtask

    task automatic m_flush(input int mode, input logic [19:0] vpn, input logic [8:0] asid);
        bit vm, am, kill;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                vm = same_page(m_vpn[s][w], m_mega[s][w], vpn);
                am = !m_perm[s][w][5] && m_asid[s][w] == asid;
                case (mode)
                    0:       kill = 1'b1;
                    1:       kill = am;
                    2:       kill = vm;
                    default: kill = vm && am;
                endcase
                if (kill) m_v[s][w] = 1'b0;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // One request cycle with any combination of lookup / fill / flush
    // ------------------------------------------------------------------
    task automatic do_cycle(input bit lk_en, input logic [19:0] lvpn, input logic [8:0] lasid,
                            input bit fill_en, input logic [19:0] fvpn, input logic [8:0] fasid,
                            input logic [21:0] fppn, input logic [7:0] fperm, input bit fmega,
                            input bit fl_en, input logic [1:0] fmode, input logic [19:0] flvpn,
                            input logic [8:0] flasid);
        bit e_hit, e_mega, ready_bad;
        logic [21:0] e_ppn;
        logic [7:0] e_perm;
        int eff, busy_cycles, exp_busy;
        @(negedge clk);
        check("lk_ready_idle", bus.lk_ready, 1);
        bus.lk_valid = lk_en;  bus.lk_vpn = lvpn;  bus.lk_asid = lasid;
        bus.fill_valid = fill_en; bus.fill_vpn = fvpn; bus.fill_asid = fasid;
        bus.fill_ppn = fppn; bus.fill_perm = fperm; bus.fill_mega = fmega;
        bus.flush_valid = fl_en; bus.flush_mode = fmode; bus.flush_vpn = flvpn; bus.flush_asid = flasid;
        if (lk_en) m_lookup(lvpn, lasid, e_hit, e_ppn, e_perm, e_mega);
        @(posedge clk); #1;
        bus.lk_valid = 1'b0; bus.fill_valid = 1'b0; bus.flush_valid = 1'b0;
        if (lk_en) begin
            check("rsp_valid", bus.rsp_valid, 1);
            check("rsp_hit",   bus.rsp_hit, e_hit);
            check("rsp_ppn",   bus.rsp_ppn, e_ppn);
            check("rsp_perm",  bus.rsp_perm, e_perm);
            check("rsp_mega",  bus.rsp_mega, e_mega);
            check("hit_count", bus.hit_count, m_hits);
            check("miss_count", bus.miss_count, m_misses);
            last_ppn = e_ppn;
        end else begin
            check("rsp_valid_idle", bus.rsp_valid, 0);
            check("rsp_ppn_hold", bus.rsp_ppn, last_ppn);
        end
        if (fl_en) begin
            eff = int'(fmode);
            if (!ASID_EN && eff == 1) eff = 0;
            if (!ASID_EN && eff == 3) eff = 2;
            m_flush(eff, flvpn, flasid);
            exp_busy = (eff != 0) ? SETS : 0;
            busy_cycles = 0; ready_bad = 1'b0;
            while (bus.flush_busy === 1'b1 && busy_cycles < SETS + 8) begin
                if (bus.lk_ready !== 1'b0) ready_bad = 1'b1;
                busy_cycles++;
                @(posedge clk); #1;
            end
            check("flush_busy_cycles", busy_cycles, exp_busy);
            if (exp_busy != 0) check("lk_ready_in_sweep", ready_bad, 0);
        end else if (fill_en) begin
            m_fill(fvpn, fasid, fppn, fperm, fmega);
        end
    endtask

    task automatic lookup(input logic [19:0] vpn, input logic [8:0] asid);
        do_cycle(1, vpn, asid, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fill(input logic [19:0] vpn, input logic [8:0] asid, input logic [21:0] ppn,
                        input logic [7:0] perm, input bit mega);
        do_cycle(0, 0, 0, 1, vpn, asid, ppn, perm, mega, 0, 0, 0, 0);
    endtask

    task automatic flush(input logic [1:0] mode, input logic [19:0] vpn, input logic [8:0] asid);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mode, vpn, asid);
    endtask

    function automatic logic [19:0] rnd_vpn();
        int vpn1, vpn0;
        vpn1 = int'($urandom_range(0, 7)) + 16 * int'($urandom_range(0, 3));
        vpn0 = int'($urandom_range(0, 3));
        return 20'(vpn1 * 1024 + vpn0);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        bus.lk_valid = 0; bus.lk_vpn = 0; bus.lk_asid = 0;
        bus.fill_valid = 0; bus.fill_vpn = 0; bus.fill_asid = 0;
        bus.fill_ppn = 0; bus.fill_perm = 0; bus.fill_mega = 0;
        bus.flush_valid = 0; bus.flush_mode = 0; bus.flush_vpn = 0; bus.flush_asid = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_lk_ready", bus.lk_ready, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_flush_busy", bus.flush_busy, 0);
        check("reset_hit_count", bus.hit_count, 0);
        check("reset_miss_count", bus.miss_count, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("lk_ready_after_reset", bus.lk_ready, 1);

        // Basic miss, refill, hit
        lookup(20'h00030, 9'd0);
        check("first_miss_count", bus.miss_count, 1);
        fill(20'h00030, 9'd0, 22'h00123, 8'hCF, 0);
        lookup(20'h00030, 9'd0);
        check("first_hit_ppn", bus.rsp_ppn, 22'h00123);
        check("first_hit_count", bus.hit_count, 1);

        // Megapage
        fill(20'h40000, 9'd0, 22'h3FC00, 8'hCF, 1);
        lookup(20'h40155, 9'd0);
        check("mega_ppn", bus.rsp_ppn, 22'h3FD55);
        check("mega_flag", bus.rsp_mega, 1);

        // Flush all, then round-robin eviction in set 0
        flush(2'b00, 0, 0);
        lookup(20'h00030, 9'd0);
        fill(20'h00000, 9'd0, 22'h00A00, 8'hCF, 0);
        fill(20'h04000, 9'd0, 22'h00A01, 8'hCF, 0);
        fill(20'h08000, 9'd0, 22'h00A02, 8'hCF, 0);
        lookup(20'h00000, 9'd0);
        check("evicted_way0", bus.rsp_hit, 0);
        lookup(20'h04000, 9'd0);
        check("kept_way1", bus.rsp_hit, 1);
        lookup(20'h08000, 9'd0);
        check("refilled_way0", bus.rsp_hit, 1);

        // ASID-tagged and global entries, ASID flush, VPN flush
        fill(20'h00450, 9'd3, 22'h00B00, 8'hCF, 0);
        fill(20'h00890, 9'd7, 22'h00B01, 8'hEF, 0);
        lookup(20'h00450, 9'd3);
        lookup(20'h00450, 9'd4);
        lookup(20'h00890, 9'd3);
        flush(2'b01, 0, 9'd3);
        lookup(20'h00450, 9'd3);
        lookup(20'h00890, 9'd3);
        fill(20'h00890, 9'd7, 22'h00B02, 8'hEF, 0);
        flush(2'b10, 20'h00890, 9'd0);
        lookup(20'h00890, 9'd7);

        // Fill and flush-all together: flush wins
        do_cycle(0, 0, 0, 1, 20'h00C20, 9'd0, 22'h00C00, 8'hCF, 0, 1, 2'b00, 0, 0);
        lookup(20'h00C20, 9'd0);
        check("fill_dropped", bus.rsp_hit, 0);
        // Lookup and fill together: lookup sees pre-fill contents
        do_cycle(1, 20'h00C24, 9'd0, 1, 20'h00C24, 9'd0, 22'h00C01, 8'hCF, 0, 0, 0, 0, 0);
        check("lookup_prefill", bus.rsp_hit, 0);
        lookup(20'h00C24, 9'd0);
        // Lookup and flush-all together: lookup sees pre-flush contents
        do_cycle(1, 20'h00C24, 9'd0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
        check("lookup_preflush", bus.rsp_hit, 1);
        lookup(20'h00C24, 9'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int op;
            op = int'($urandom_range(0, 99));
            do_cycle($urandom_range(0, 1) == 1, rnd_vpn(), 9'($urandom_range(0, 3)),
                     op < 45, rnd_vpn(), 9'($urandom_range(0, 3)), 22'($urandom),
                     8'($urandom), $urandom_range(0, 3) == 0,
                     op >= 92, 2'($urandom_range(0, 3)), rnd_vpn(), 9'($urandom_range(0, 3)));
        end

        // Miss counter saturation
        flush(2'b00, 0, 0);
        for (int i = 0; i < MAXC + 3; i++) lookup(rnd_vpn(), 9'd0);
        check("miss_count_saturated", bus.miss_count, MAXC);

        // Reset in the middle of a sweep
        fill(20'h01010, 9'd1, 22'h00D00, 8'hEF, 0);
        fill(20'h02020, 9'd1, 22'h00D01, 8'hCF, 1);
        lookup(20'h01010, 9'd1);
        @(negedge clk);
        bus.flush_valid = 1'b1; bus.flush_mode = 2'b10; bus.flush_vpn = 20'h3FFFF;
        @(posedge clk); #1;
        bus.flush_valid = 1'b0;
        check("sweep_started", bus.flush_busy, 1);
        repeat (5) @(posedge clk);
        @(negedge clk); reset = 1'b1; #1;
        check("abort_flush_busy", bus.flush_busy, 0);
        check("abort_lk_ready", bus.lk_ready, 0);
        check("abort_miss_count", bus.miss_count, 0);
        m_reset();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_abort", bus.lk_ready, 1);
        lookup(20'h01010, 9'd1);
        check("post_reset_miss_4k", bus.rsp_hit, 0);
        lookup(20'h02020, 9'd1);
        check("post_reset_miss_mega", bus.rsp_hit, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sv32_tlb_nway
`default_nettype wire

// File: doc/sv32_tlb_nway.md
Name: sv32_tlb_nway

Overview:
- Parametrised N-way set-associative Sv32 TLB; next generation of the fixed 2-way TLB inside the sv32 MMU.
- Sits between the MMU translate stage and the page-table walker. The MMU issues lookups; the walker issues refills.
- Adds 4 MiB megapage entries, per-set round-robin replacement, selective flush (by ASID / by VPN) and hit/miss counters.

Parameters:
- SETS, 16: number of sets; power of 2, range 2..64.
- WAYS, 2: ways per set; range 1..8.
- CNT_W, 32: width of the hit and miss counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- lk_valid  in  1  lookup request.
- lk_ready  out  1  lookup can be accepted.
- lk_vpn  in  20  virtual page number {VPN1,VPN0}.
- lk_asid  in  9  current ASID.
- rsp_valid  out  1  lookup result valid; 1-cycle pulse.
- rsp_hit  out  1  result was a hit.
- rsp_ppn  out  22  translated PPN.
- rsp_perm  out  8  {D,A,G,U,X,W,R,V} of the hit entry.
- rsp_mega  out  1  hit entry is a megapage.
- fill_valid  in  1  refill write.
- fill_vpn  in  20  refill VPN.
- fill_asid  in  9  refill ASID.
- fill_ppn  in  22  refill PPN.
- fill_perm  in  8  refill PTE flags.
- fill_mega  in  1  refill is a 4 MiB leaf.
- flush_valid  in  1  flush request.
- flush_mode  in  2  flush scope (see Behaviour).
- flush_vpn  in  20  flush VPN.
- flush_asid  in  9  flush ASID.
- flush_busy  out  1  selective flush in progress.
- hit_count  out  CNT_W  count of lookup hits.
- miss_count  out  CNT_W  count of lookup misses.

Behaviour:
- Reset:
  - All valid bits, counters and rsp_* outputs go to 0.
  - flush_busy=0; FSM enters IDLE.
  - lk_ready=0 while reset is asserted, 1 from the first clk edge after release.
- Set index: lk_vpn[10+log2(SETS)-1:10], i.e. low bits of VPN1. 4K pages and megapages share the same index.
- Match (per way):
  - V=1, and
  - tag match: megapage compares VPN1 only; 4K page compares the full VPN, and
  - ASID match: G=1 or entry ASID == lk_asid.
  - At most one way matches. If more than one matches, the lowest way index wins.
- Lookup latency:
  - Accepted when lk_valid && lk_ready.
  - rsp_valid pulses exactly 1 cycle later. rsp_* hold until the next response.
  - On a miss, rsp_ppn=0 and rsp_perm=0.
  - Megapage hit: rsp_ppn = {entry_ppn[21:10], lk_vpn[9:0]}.
- Fill:
  - Takes effect at the clk edge on which fill_valid is sampled, and only while the FSM is in IDLE. A fill while flush_busy=1 is dropped; the walker must wait.
  - Way choice, in priority order:
    1. an existing way matching fill_vpn/fill_asid (overwrite, no duplicates);
    2. otherwise the lowest invalid way;
    3. otherwise the set's round-robin pointer way.
  - The round-robin pointer increments mod WAYS only when case 3 is used.
- Simultaneous events:
  - Lookup and fill in the same cycle to the same VPN: the lookup sees the pre-fill contents (miss).
  - Flush and fill in the same cycle: the flush wins and the fill is dropped.
- FSM states: IDLE, SWEEP.
- flush_mode 00 (all):
  - Clears every valid bit at the sampling edge.
  - Stays in IDLE; flush_busy never asserts.
  - A lookup in the same cycle still responds, using the pre-flush contents.
- flush_mode 01 (ASID, non-global only), 10 (VPN, any ASID), 11 (VPN+ASID, non-global only):
  - IDLE -> SWEEP. flush_busy=1 and lk_ready=0 for exactly SETS cycles.
  - One set is examined per cycle, set 0 first, and matching ways are invalidated.
  - SWEEP -> IDLE after the last set.
- flush_valid while in SWEEP is ignored.
- reset during SWEEP aborts the sweep; all entries are invalid after reset.
- Counters:
  - hit_count increments on rsp_valid && rsp_hit.
  - miss_count increments on rsp_valid && !rsp_hit.
  - Both saturate at 2^CNT_W-1. Only reset clears them.

Optional Feature:
- Macro: SV32_TLB_ASID_EN.
- Defined: ASID tags are stored and compared as described above.
- Undefined:
  - No ASID storage; lk_asid, fill_asid and flush_asid are ignored.
  - Every entry matches regardless of G.
  - flush_mode 01 behaves as 00; flush_mode 11 behaves as 10.

Test Plan:
- Reset, then lookup vpn=0x00030 -> rsp_valid one cycle later with rsp_hit=0 and miss_count=1. Fill vpn=0x00030, ppn=0x00123, perm=0xCF, then lookup again -> rsp_hit=1, rsp_ppn=0x00123, hit_count=1.
- Fill a megapage: vpn=0x40000, ppn=0x3FC00, fill_mega=1. Lookup vpn=0x40155 -> rsp_hit=1, rsp_mega=1, rsp_ppn=0x3FD55.
- WAYS=2, SETS=16: fill vpn 0x00000, 0x04000, 0x08000 (all index 0) -> the third fill evicts way 0. Lookup 0x00000 misses; 0x04000 and 0x08000 hit.
- With SV32_TLB_ASID_EN: fill vpn=0x00050 with asid=3, G=0. Lookups with asid=3 hit and asid=4 miss. flush_mode=01, flush_asid=3 -> flush_busy high for exactly 16 cycles; afterwards the asid=3 lookup misses while global entries still hit.
- Drive fill and flush_mode=00 in the same cycle -> the fill is dropped and a subsequent lookup of the fill VPN misses. Assert reset mid-SWEEP -> flush_busy=0 and all lookups miss.
- Preload miss_count to 2^CNT_W-2 (CNT_W=4 build), then perform 3 misses -> miss_count stays at 15.
